lfsr_crypt_engine: RTL



---
 rtl/crypt_pkg.sv | 76 +++++++
 rtl/lfsr8_step.sv | 51 +++++
 rtl/lfsr_crypt_engine.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/crypt_pkg.sv
// -----------------------------------------------------------------------------
// crypt_pkg
// Shared definitions for the LFSR pad-and-encrypt engine:
//   - memory map and sizing constants (message, output, parameter block)
//   - FSM state encoding
//   - the padding byte and the eight legal LFSR tap patterns
//   - parity / LFSR-step / pad-decision helper functions
// -----------------------------------------------------------------------------
package crypt_pkg;

    // Memory address width of the data RAM port.
    localparam int unsigned AW = 32'd8;

    // Plaintext length, output length and memory map.
    localparam logic [7:0] MSG_LEN    = 8'd41;
    localparam logic [7:0] OUT_LEN    = 8'd64;
    localparam logic [7:0] PARAM_BASE = 8'd41;
    localparam logic [7:0] OUT_BASE   = 8'd64;

    // Index of the final output byte.
    localparam logic [6:0] LAST_IDX   = 7'(OUT_LEN - 8'd1);

    // Padding byte (ASCII space).
    localparam logic [7:0] PAD_CHAR   = 8'h20;

    // The eight legal feedback tap patterns.
    localparam logic [7:0] TAP_E1 = 8'he1;
    localparam logic [7:0] TAP_D4 = 8'hd4;
    localparam logic [7:0] TAP_C6 = 8'hc6;
    localparam logic [7:0] TAP_B8 = 8'hb8;
    localparam logic [7:0] TAP_B4 = 8'hb4;
    localparam logic [7:0] TAP_B2 = 8'hb2;
    localparam logic [7:0] TAP_FA = 8'hfa;
    localparam logic [7:0] TAP_F3 = 8'hf3;

    // Engine sequencer states.
    typedef enum logic [3:0] {
        RD_PRE   = 4'd0,
        RD_TAP   = 4'd1,
        RD_INIT  = 4'd2,
        CAP_INIT = 4'd3,
        BYTE     = 4'd4,
        RD_MSG   = 4'd5,
        WR       = 4'd6,
        WR_PAD   = 4'd7,
        DONE     = 4'd8
    } state_t;

    // Even parity (XOR reduction) of a byte.
    function automatic logic parity8(input logic [7:0] v);
        return ^v;
    endfunction

    // One LFSR step: shift left, feed back the parity of the tapped bits.
    function automatic logic [7:0] lfsr_next(input logic [7:0] cur, input logic [7:0] tap);
        return {cur[6:0], parity8(cur & tap)};
    endfunction

    // True when output byte idx is a pad byte for the given pre_length:
    // either inside the leading pad region or past the end of the message.
    function automatic logic byte_is_pad(input logic [6:0] idx, input logic [7:0] pre);
        logic [7:0] idx8;
        logic [7:0] k;
        logic       pad;
        idx8 = {1'b0, idx};
        k    = 8'h00;
        if (idx8 < pre) begin
            pad = 1'b1;
        end else begin
            k   = idx8 - pre;
            pad = (k >= MSG_LEN);
        end
        return pad;
    endfunction

endpackage

// File: rtl/lfsr8_step.sv
// -----------------------------------------------------------------------------
// lfsr8_step
// Registered 8-bit Fibonacci-style LFSR used as the keystream generator.
// Ports:
//   CLK      - clock, rising edge
//   start    - synchronous active-high reset (register cleared to 0)
//   load     - load load_val into the register (priority over advance)
//   load_val - seed value
//   advance  - step the register by one LFSR shift
//   tap      - feedback tap pattern
//   q        - current register value
//   q_next   - value the register would take on the next advance
// -----------------------------------------------------------------------------
module lfsr8_step
    import crypt_pkg::*;
(
    input  logic       CLK,
    input  logic       start,
    input  logic       load,
    input  logic [7:0] load_val,
    input  logic       advance,
    input  logic [7:0] tap,
    output logic [7:0] q,
    output logic [7:0] q_next
);

    logic [7:0] lfsr_r;
    logic [7:0] step_s;

    // One-step look-ahead of the keystream.
    always_comb begin
        step_s = lfsr_next(lfsr_r, tap);
    end

    // Keystream register: clear on start, seed on load, step on advance.
    always_ff @(posedge CLK) begin
        if (start) begin
            lfsr_r <= 8'h00;
        end else if (load) begin
            lfsr_r <= load_val;
        end else if (advance) begin
            lfsr_r <= step_s;
        end else begin
            lfsr_r <= lfsr_r;
        end
    end

    assign q      = lfsr_r;
    assign q_next = step_s;

endmodule

// File: rtl/lfsr_crypt_engine.sv
// -----------------------------------------------------------------------------
// lfsr_crypt_engine
// Fixed-function pad-and-encrypt engine acting as an alternate master on the
// data RAM. Reads pre_length / tap / seed from the parameter block, then writes
// OUT_LEN bytes to OUT_BASE..: leading pad bytes, message bytes, trailing pad
// bytes, each XORed with the running LFSR keystream. Raises done when finished.
//
// Ports:
//   CLK        - clock, all logic on rising edge
//   start      - synchronous active-high reset; deassertion begins a run
//   mem_addr   - RAM address
//   mem_wr_en  - RAM write strobe (write at rising edge)
//   mem_wdata  - RAM write data
//   mem_rdata  - RAM read data, valid the cycle after the address is driven
//   done       - run complete, held until start
//   cycle_cnt  - (only with CRYPT_PERF_CNT_EN) edges from run start to done,
//                saturating at 16'hFFFF
//
// Build option: define CRYPT_PERF_CNT_EN to add the cycle_cnt counter/port.
// -----------------------------------------------------------------------------
module lfsr_crypt_engine
    import crypt_pkg::*;
(
    input  logic          CLK,
    input  logic          start,
    output logic [AW-1:0] mem_addr,
    output logic          mem_wr_en,
    output logic [7:0]    mem_wdata,
    input  logic [7:0]    mem_rdata,
    output logic          done
`ifdef CRYPT_PERF_CNT_EN
    ,
    output logic [15:0]   cycle_cnt
`endif
);

    state_t     state_r;
    logic [6:0] idx_r;
    logic [7:0] pre_r;
    logic [7:0] tap_r;
    logic [7:0] wdata_r;

    logic [7:0] lfsr_s;
    logic [7:0] lfsr_nxt_s;
    logic       load_s;
    logic       advance_s;

    // Description of the next byte to issue.
    logic [6:0] nb_idx_s;
    logic [7:0] nb_lfsr_s;
    logic [7:0] nb_k_s;
    logic       nb_pad_s;
    logic       last_s;

    lfsr8_step u_lfsr (
        .CLK      (CLK),
        .start    (start),
        .load     (load_s),
        .load_val (mem_rdata),
        .advance  (advance_s),
        .tap      (tap_r),
        .q        (lfsr_s),
        .q_next   (lfsr_nxt_s)
    );

    // Keystream control: seed in CAP_INIT, step once after every write.
    always_comb begin
        load_s    = (state_r == CAP_INIT);
        advance_s = (state_r == WR) || (state_r == WR_PAD);
    end

    // Next-byte look-ahead. From BYTE the byte to issue is the current idx;
    // from a write state it is idx+1 with the already-stepped keystream, so the
    // next byte is issued on the same edge as the write with no gap cycle.
    always_comb begin
        nb_idx_s  = idx_r;
        nb_lfsr_s = lfsr_s;
        if (state_r == BYTE) begin
            nb_idx_s  = idx_r;
            nb_lfsr_s = lfsr_s;
        end else begin
            nb_idx_s  = idx_r + 7'd1;
            nb_lfsr_s = lfsr_nxt_s;
        end
        nb_pad_s = byte_is_pad(nb_idx_s, pre_r);
        nb_k_s   = {1'b0, nb_idx_s} - pre_r;
        last_s   = (idx_r == LAST_IDX);
    end

    // Message bytes only arrive from the RAM during WR itself, so their cipher
    // byte is formed directly from mem_rdata; pad bytes come from a register.
    always_comb begin
        if (state_r == WR) begin
            mem_wdata = mem_rdata ^ lfsr_s;
        end else begin
            mem_wdata = wdata_r;
        end
    end

    // Main sequencer with registered bus outputs.
    always_ff @(posedge CLK) begin
        if (start) begin
            state_r   <= RD_PRE;
            mem_addr  <= PARAM_BASE;
            mem_wr_en <= 1'b0;
            wdata_r   <= 8'h00;
            done      <= 1'b0;
            idx_r     <= 7'd0;
            tap_r     <= 8'h00;
            pre_r     <= 8'h00;
        end else begin
            case (state_r)
                RD_PRE: begin
                    mem_addr <= PARAM_BASE + 8'd1;
                    state_r  <= RD_TAP;
                end
                RD_TAP: begin
                    pre_r    <= mem_rdata;
                    mem_addr <= PARAM_BASE + 8'd2;
                    state_r  <= RD_INIT;
                end
                RD_INIT: begin
                    tap_r   <= mem_rdata;
                    state_r <= CAP_INIT;
                end
                CAP_INIT: begin
                    // Seed is loaded into u_lfsr by load_s on this edge.
                    idx_r   <= 7'd0;
                    state_r <= BYTE;
                end
                BYTE, WR, WR_PAD: begin
                    if ((state_r != BYTE) && last_s) begin
                        idx_r     <= idx_r + 7'd1;
                        mem_wr_en <= 1'b0;
                        done      <= 1'b1;
                        state_r   <= DONE;
                    end else begin
                        idx_r <= nb_idx_s;
                        if (nb_pad_s) begin
                            mem_addr  <= OUT_BASE + {1'b0, nb_idx_s};
                            mem_wr_en <= 1'b1;
                            wdata_r   <= PAD_CHAR ^ nb_lfsr_s;
                            state_r   <= WR_PAD;
                        end else begin
                            mem_addr  <= nb_k_s;
                            mem_wr_en <= 1'b0;
                            state_r   <= RD_MSG;
                        end
                    end
                end
                RD_MSG: begin
                    mem_addr  <= OUT_BASE + {1'b0, idx_r};
                    mem_wr_en <= 1'b1;
                    state_r   <= WR;
                end
                DONE: begin
                    mem_wr_en <= 1'b0;
                    done      <= 1'b1;
                    state_r   <= DONE;
                end
                default: begin
                    state_r   <= RD_PRE;
                    mem_addr  <= PARAM_BASE;
                    mem_wr_en <= 1'b0;
                    done      <= 1'b0;
                end
            endcase
        end
    end

`ifdef CRYPT_PERF_CNT_EN
    logic [15:0] cycle_cnt_r;

    // Run-length counter: counts edges until done, freezes after, saturates.
    always_ff @(posedge CLK) begin
        if (start) begin
            cycle_cnt_r <= 16'h0000;
        end else if (!done && (cycle_cnt_r != 16'hFFFF)) begin
            cycle_cnt_r <= cycle_cnt_r + 16'h0001;
        end else begin
            cycle_cnt_r <= cycle_cnt_r;
        end
    end

    assign cycle_cnt = cycle_cnt_r;
`endif

endmodule
